// File: rtl/asc_pkg.sv
// rtl/asc_pkg.sv - shared state type, response codes and frame sizing for the ASC packet assembler
package asc_pkg;

  typedef enum logic [1:0] {COLLECT, CHECK, PRESENT, RESP} asc_state_e;

  localparam logic [7:0] ASC_ACK = 8'h06;
  localparam logic [7:0] ASC_NAK = 8'h15;

  localparam int ASC_ADDR_BITS_DEFAULT    = 12;
  localparam int ASC_PAYLOAD_BITS_DEFAULT = 160;

  function automatic int bytes_of(input int bits);
    return (bits + 7) / 8;
  endfunction

  localparam int ASC_ADDR_BYTES    = bytes_of(ASC_ADDR_BITS_DEFAULT);
  localparam int ASC_PAYLOAD_BYTES = bytes_of(ASC_PAYLOAD_BITS_DEFAULT);
  localparam int ASC_TOTAL         = ASC_ADDR_BYTES + ASC_PAYLOAD_BYTES;

endpackage

// File: rtl/asc_packet_assembler_if.sv
// rtl/asc_packet_assembler_if.sv - byte-in, packet-out and response handshakes of the assembler
interface asc_packet_assembler_if #(
  parameter int ADDR_BITS    = 12,
  parameter int PAYLOAD_BITS = 160
);
  logic                    data_valid;
  logic                    data_ready;
  logic [7:0]              data_in;
  logic                    pkt_valid;
  logic                    pkt_ready;
  logic [ADDR_BITS-1:0]    pkt_addr;
  logic [PAYLOAD_BITS-1:0] pkt_payload;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [7:0]              resp_data;

  modport master (
    output data_valid, data_in, pkt_ready, resp_ready,
    input  data_ready, pkt_valid, pkt_addr, pkt_payload, resp_valid, resp_data
  );

  modport slave (
    input  data_valid, data_in, pkt_ready, resp_ready,
    output data_ready, pkt_valid, pkt_addr, pkt_payload, resp_valid, resp_data
  );
endinterface

// File: rtl/asc_idle_timer.sv
// rtl/asc_idle_timer.sv - idle cycle counter; expire is high while the count sits at TIMEOUT_CYCLES-1
module asc_idle_timer #(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);
  localparam int            CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != LAST)) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = enable && (cnt_q == LAST);
endmodule

// File: rtl/asc_packet_assembler.sv
// rtl/asc_packet_assembler.sv - collects ASC bytes into one {addr, payload} scan packet and answers ACK/NAK
// Optional trailing XOR checksum byte enabled by defining ASC_ASSEMBLER_CHECKSUM_EN.
module asc_packet_assembler
  import asc_pkg::*;
#(
  parameter int ADDR_BITS      = 12,
  parameter int PAYLOAD_BITS   = 160,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                        clk,
  input  logic                        reset,
  asc_packet_assembler_if.slave       bus,
  output logic                        timeout_err,
  output logic [4:0]                  byte_count
);
  localparam int ADDR_BYTES    = bytes_of(ADDR_BITS);
  localparam int PAYLOAD_BYTES = bytes_of(PAYLOAD_BITS);
  localparam int TOTAL         = ADDR_BYTES + PAYLOAD_BYTES;
  localparam int SR_W          = TOTAL * 8;
`ifdef ASC_ASSEMBLER_CHECKSUM_EN
  localparam int FRAME_BYTES   = TOTAL + 1;
`else
  localparam int FRAME_BYTES   = TOTAL;
`endif
  localparam logic [4:0] LAST_IDX = 5'(FRAME_BYTES - 1);

  asc_state_e              state_q, state_d;
  logic [4:0]              count_q, count_d;
  logic [SR_W-1:0]         sreg_q, sreg_d;
  logic                    data_ready_q, data_ready_d;
  logic                    pkt_valid_q, pkt_valid_d;
  logic [ADDR_BITS-1:0]    pkt_addr_q, pkt_addr_d;
  logic [PAYLOAD_BITS-1:0] pkt_payload_q, pkt_payload_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [7:0]              resp_data_q, resp_data_d;
  logic                    timeout_q, timeout_d;
  logic [4:0]              byte_count_q, byte_count_d;
`ifdef ASC_ASSEMBLER_CHECKSUM_EN
  logic [7:0]              csum_q, csum_d;
  logic                    csum_ok_q, csum_ok_d;
`endif

  logic accept;
  logic timer_en;
  logic expire;

  assign accept   = bus.data_valid && data_ready_q;
  assign timer_en = (state_q == COLLECT) && (count_q != 5'd0);

  asc_idle_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_idle_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (accept || !timer_en),
    .enable (timer_en),
    .expire (expire)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sreg_d      = sreg_q;
    resp_data_d = resp_data_q;
    timeout_d   = 1'b0;
`ifdef ASC_ASSEMBLER_CHECKSUM_EN
    csum_d      = csum_q;
    csum_ok_d   = csum_ok_q;
`endif
    unique case (state_q)
      COLLECT: begin
        // An accepted byte beats a simultaneous timer expiry.
        if (accept) begin
          count_d = count_q + 5'd1;
          if (count_q < 5'(TOTAL)) begin
            sreg_d = {sreg_q[SR_W-9:0], bus.data_in};
          end
`ifdef ASC_ASSEMBLER_CHECKSUM_EN
          csum_d = csum_q ^ bus.data_in;
          if (count_q == LAST_IDX) begin
            state_d   = CHECK;
            csum_ok_d = (csum_q == bus.data_in);
          end
`else
          if (count_q == LAST_IDX) begin
            state_d = PRESENT;
          end
`endif
        end else if (expire) begin
          timeout_d   = 1'b1;
          count_d     = 5'd0;
          state_d     = RESP;
          resp_data_d = ASC_NAK;
        end
      end
`ifdef ASC_ASSEMBLER_CHECKSUM_EN
      CHECK: begin
        if (csum_ok_q) begin
          state_d = PRESENT;
        end else begin
          state_d     = RESP;
          resp_data_d = ASC_NAK;
        end
      end
`endif
      PRESENT: begin
        if (pkt_valid_q && bus.pkt_ready) begin
          state_d     = RESP;
          resp_data_d = ASC_ACK;
        end
      end
      RESP: begin
        if (resp_valid_q && bus.resp_ready) begin
          state_d = COLLECT;
          count_d = 5'd0;
          sreg_d  = '0;
`ifdef ASC_ASSEMBLER_CHECKSUM_EN
          csum_d  = 8'h00;
`endif
        end
      end
      default: state_d = COLLECT;
    endcase

    // Outputs are registered copies of the next-state decode.
    data_ready_d  = (state_d == COLLECT);
    pkt_valid_d   = (state_d == PRESENT);
    resp_valid_d  = (state_d == RESP);
    byte_count_d  = count_d;
    pkt_addr_d    = pkt_addr_q;
    pkt_payload_d = pkt_payload_q;
    if (state_d == PRESENT) begin
      pkt_addr_d    = sreg_d[PAYLOAD_BYTES*8 +: ADDR_BITS];
      pkt_payload_d = sreg_d[PAYLOAD_BITS-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= COLLECT;
      count_q       <= 5'd0;
      sreg_q        <= '0;
      data_ready_q  <= 1'b0;
      pkt_valid_q   <= 1'b0;
      pkt_addr_q    <= '0;
      pkt_payload_q <= '0;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= 8'h00;
      timeout_q     <= 1'b0;
      byte_count_q  <= 5'd0;
`ifdef ASC_ASSEMBLER_CHECKSUM_EN
      csum_q        <= 8'h00;
      csum_ok_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      sreg_q        <= sreg_d;
      data_ready_q  <= data_ready_d;
      pkt_valid_q   <= pkt_valid_d;
      pkt_addr_q    <= pkt_addr_d;
      pkt_payload_q <= pkt_payload_d;
      resp_valid_q  <= resp_valid_d;
      resp_data_q   <= resp_data_d;
      timeout_q     <= timeout_d;
      byte_count_q  <= byte_count_d;
`ifdef ASC_ASSEMBLER_CHECKSUM_EN
      csum_q        <= csum_d;
      csum_ok_q     <= csum_ok_d;
`endif
    end
  end

  assign bus.data_ready  = data_ready_q;
  assign bus.pkt_valid   = pkt_valid_q;
  assign bus.pkt_addr    = pkt_addr_q;
  assign bus.pkt_payload = pkt_payload_q;
  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_data   = resp_data_q;
  assign timeout_err     = timeout_q;
  assign byte_count      = byte_count_q;
endmodule

// File: tb/tb_asc_packet_assembler.sv
// tb/tb_asc_packet_assembler.sv - randomized self-checking bench for asc_packet_assembler
module tb_asc_packet_assembler;
  localparam int AB = 12;
  localparam int PB = 160;
  localparam int TO = 100;
  localparam int ADDR_BYTES = 2;
  localparam int TOTAL = 22;
  localparam logic [7:0] ACK = 8'h06;
  localparam logic [7:0] NAK = 8'h15;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       timeout_err;
  logic [4:0] byte_count;
  int checks = 0;
  int errors = 0;
  int pkt_count = 0;
  int resp_count = 0;
  int to_count = 0;
  logic [7:0] cur[$];

  asc_packet_assembler_if #(.ADDR_BITS(AB), .PAYLOAD_BITS(PB)) bus ();

  asc_packet_assembler #(.ADDR_BITS(AB), .PAYLOAD_BITS(PB), .TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .bus         (bus),
    .timeout_err (timeout_err),
    .byte_count  (byte_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.pkt_valid && bus.pkt_ready) pkt_count <= pkt_count + 1;
    if (bus.resp_valid && bus.resp_ready) resp_count <= resp_count + 1;
    if (timeout_err) to_count <= to_count + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic check_eq(input string tag, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [191:0] model_addr();
    logic [191:0] v = '0;
    for (int i = 0; i < ADDR_BYTES; i++) v = (v << 8) | 192'(cur[i]);
    return v & ((192'd1 << AB) - 192'd1);
  endfunction

  function automatic logic [191:0] model_payload();
    logic [191:0] v = '0;
    for (int i = ADDR_BYTES; i < TOTAL; i++) v = (v << 8) | 192'(cur[i]);
    return v & ((192'd1 << PB) - 192'd1);
  endfunction

  function automatic logic [7:0] model_xor();
    logic [7:0] x = 8'h00;
    foreach (cur[i]) x = x ^ cur[i];
    return x;
  endfunction

  task automatic fixed_frame(input logic [7:0] first);
    cur.delete();
    cur.push_back(first);
    cur.push_back(8'hBC);
    for (int i = 1; i <= 20; i++) cur.push_back(8'(i));
  endtask

  task automatic random_frame();
    cur.delete();
    for (int i = 0; i < TOTAL; i++) cur.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.data_valid = 1'b1;
    bus.data_in    = b;
    while (!bus.data_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.data_ready) check_eq("data_ready_wait", 0, 1);
    @(negedge clk);
    bus.data_valid = 1'b0;
  endtask

  task automatic send_bytes(input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      send_byte(cur[i]);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic send_frame();
    send_bytes(0, TOTAL);
`ifdef ASC_ASSEMBLER_CHECKSUM_EN
    send_byte(model_xor());
`endif
  endtask

  task automatic take_packet(input int hold, input logic [191:0] ea, input logic [191:0] ep);
    int n = 0;
    logic bad = 1'b0;
    logic [AB-1:0] a0;
    logic [PB-1:0] p0;
    while (!bus.pkt_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("pkt_valid_seen", bus.pkt_valid, 1);
    a0 = bus.pkt_addr;
    p0 = bus.pkt_payload;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.pkt_addr !== a0 || bus.pkt_payload !== p0) bad = 1'b1;
      if (bus.data_ready || bus.resp_valid || !bus.pkt_valid) bad = 1'b1;
    end
    if (hold > 0) check_eq("pkt_hold_stable", bad, 0);
    check_eq("pkt_addr", bus.pkt_addr, ea);
    check_eq("pkt_payload", bus.pkt_payload, ep);
    bus.pkt_ready = 1'b1;
    @(negedge clk);
    bus.pkt_ready = 1'b0;
  endtask

  task automatic take_resp(input string tag, input logic [7:0] exp);
    int n = 0;
    while (!bus.resp_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_eq("resp_valid_seen", bus.resp_valid, 1);
    check_eq(tag, bus.resp_data, exp);
    repeat ($urandom_range(0, 3)) @(negedge clk);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  initial begin
    int n;
    int pc;
    int rc;
    int tc;
    bus.data_valid = 1'b0;
    bus.data_in    = 8'h00;
    bus.pkt_ready  = 1'b0;
    bus.resp_ready = 1'b0;

    @(negedge clk);
    check_eq("rst_data_ready", bus.data_ready, 0);
    check_eq("rst_pkt_valid", bus.pkt_valid, 0);
    check_eq("rst_resp_valid", bus.resp_valid, 0);
    check_eq("rst_byte_count", byte_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_eq("rel_ready_before_clk", bus.data_ready, 0);
    @(negedge clk);
    check_eq("rel_data_ready", bus.data_ready, 1);

    // Known frame, immediate handshakes
    fixed_frame(8'h0A);
    send_frame();
    take_packet(0, 192'hABC, 192'h0102030405060708090A0B0C0D0E0F1011121314);
    take_resp("t1_ack", ACK);
    check_eq("t1_ready_after_resp", bus.data_ready, 1);

    // Shifter stalls for 50 cycles
    fixed_frame(8'h0A);
    send_frame();
    take_packet(50, 192'hABC, 192'h0102030405060708090A0B0C0D0E0F1011121314);
    take_resp("t2_ack", ACK);

    // Address bits above ADDR_BITS are dropped
    fixed_frame(8'hFA);
    send_frame();
    take_packet(0, 192'hABC, 192'h0102030405060708090A0B0C0D0E0F1011121314);
    take_resp("t3_ack", ACK);

    // Partial frame then silence
    random_frame();
    tc = to_count;
    pc = pkt_count;
    send_bytes(0, 5);
    check_eq("t4_byte_count", byte_count, 5);
    n = 0;
    while (!timeout_err && n < 3 * TO) begin
      @(negedge clk);
      n++;
    end
    check_eq("t4_timeout_seen", timeout_err, 1);
    check_eq("t4_byte_count_zero", byte_count, 0);
    @(negedge clk);
    check_eq("t4_pulse_width", timeout_err, 0);
    take_resp("t4_nak", NAK);
    check_eq("t4_timeout_pulses", to_count - tc, 1);
    check_eq("t4_no_pkt", pkt_count - pc, 0);
    fixed_frame(8'h0A);
    send_frame();
    take_packet(0, 192'hABC, 192'h0102030405060708090A0B0C0D0E0F1011121314);
    take_resp("t4_after_ack", ACK);

    // Exact idle latency: last byte then silence must time out after TO cycles
    random_frame();
    send_byte(cur[0]);
    n = 0;
    while (!timeout_err && n < 3 * TO) begin
      @(negedge clk);
      n++;
    end
    check_eq("timeout_latency", n, TO);
    take_resp("lat_nak", NAK);

    // Byte arriving on the expiry cycle wins
    random_frame();
    tc = to_count;
    send_byte(cur[0]);
    repeat (TO - 1) @(negedge clk);
    send_bytes(1, TOTAL);
`ifdef ASC_ASSEMBLER_CHECKSUM_EN
    send_byte(model_xor());
`endif
    take_packet(0, model_addr(), model_payload());
    take_resp("race_ack", ACK);
    check_eq("race_no_timeout", to_count - tc, 0);

    // Idle link with no bytes never times out
    tc = to_count;
    repeat (3 * TO) @(negedge clk);
    check_eq("idle_no_timeout", to_count - tc, 0);
    check_eq("idle_no_resp", bus.resp_valid, 0);

    // Reset mid-packet
    random_frame();
    send_bytes(0, 10);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_byte_count", byte_count, 0);
    check_eq("mid_rst_data_ready", bus.data_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pc = pkt_count;
    rc = resp_count;
    @(negedge clk);
    check_eq("mid_rel_ready", bus.data_ready, 1);
    check_eq("mid_rel_pkt_valid", bus.pkt_valid, 0);
    check_eq("mid_rel_resp_valid", bus.resp_valid, 0);
    fixed_frame(8'h0A);
    send_frame();
    take_packet(0, 192'hABC, 192'h0102030405060708090A0B0C0D0E0F1011121314);
    take_resp("t5_ack", ACK);
    check_eq("t5_one_pkt", pkt_count - pc, 1);
    check_eq("t5_one_resp", resp_count - rc, 1);

    // Random frames with random stalls
    for (int k = 0; k < 20; k++) begin
      random_frame();
      send_frame();
      take_packet($urandom_range(0, 5), model_addr(), model_payload());
      take_resp("rand_ack", ACK);
    end

`ifdef ASC_ASSEMBLER_CHECKSUM_EN
    // Wrong checksum: NAK and no packet
    random_frame();
    pc = pkt_count;
    send_bytes(0, TOTAL);
    send_byte(~model_xor());
    take_resp("t6_nak", NAK);
    check_eq("t6_no_pkt", pkt_count - pc, 0);
    random_frame();
    send_frame();
    take_packet(0, model_addr(), model_payload());
    take_resp("t6_good_ack", ACK);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
